// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A small host register bank provides enable,
// vblank interrupt status, a frame counter and a beam position readback.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic        hsync,
  output logic        vsync,
  output logic        video_active,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(HT - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(VT - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_VBLANK = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic        pending_q, pending_d;
  logic [15:0] frame_q, frame_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_active_q, video_active_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;

  logic        wr_en;
  logic        aligned;
  logic        sel_ctrl;
  logic        sel_status;
  logic        vblank;
  logic [31:0] rd_word;
  logic        unused_data;

  assign unused_data = ^data_in[31:2];
  assign wr_en       = (data_write_n != 2'b11);
  assign aligned     = (address[1:0] == 2'b00);
  assign sel_ctrl    = aligned && (address[5:2] == 4'd0);
  assign sel_status  = aligned && (address[5:2] == 4'd1);
  assign vblank      = enable_q && (h_cnt_q == H_LAST) && (v_cnt_q == V_VBLANK);

  // Raster counters sit at the origin whenever the generator is disabled.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable_q) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 11'd1;
    end
  end

  always_comb begin
    video_active_d = enable_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    pix_x_d        = video_active_d ? h_cnt_q[9:0] : '0;
    pix_y_d        = video_active_d ? v_cnt_q : '0;
    hsync_d        = (enable_q && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d        = (enable_q && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Vblank is applied after the W1C so a coincident clear cannot lose the event.
  always_comb begin
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    if (wr_en && sel_ctrl) begin
      enable_d = data_in[0];
      irq_en_d = data_in[1];
    end
    if (wr_en && sel_status && data_in[0]) begin
      pending_d = 1'b0;
    end
    if (vblank) begin
      pending_d = 1'b1;
      frame_d   = frame_q + 16'd1;
    end
  end

  always_comb begin
    rd_word = '0;
    if (aligned) begin
      case (address[5:2])
        4'd0:    rd_word = {30'd0, irq_en_q, enable_q};
        4'd1:    rd_word = {31'd0, pending_q};
        4'd2:    rd_word = {16'd0, frame_q};
        4'd3:    rd_word = {6'd0, v_cnt_q, 5'd0, h_cnt_q};
        default: rd_word = '0;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    case (data_read_n)
      2'b00:   data_out = {24'd0, rd_word[7:0]};
      2'b01:   data_out = {16'd0, rd_word[15:0]};
      2'b10:   data_out = rd_word;
      default: data_out = '0;
    endcase
  end

  assign data_ready     = (data_read_n != 2'b11);
  assign user_interrupt = pending_q & irq_en_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign video_active   = video_active_q;
  assign pix_x          = pix_x_q;
  assign pix_y          = pix_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      pending_q      <= 1'b0;
      frame_q        <= '0;
      hsync_q        <= ~SYNC_POL;
      vsync_q        <= ~SYNC_POL;
      video_active_q <= 1'b0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      pending_q      <= pending_d;
      frame_q        <= frame_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_active_q <= video_active_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
    end
  end

endmodule
